lcd_nibble_reader: RTL and testbench
====================================

Name: lcd_nibble_reader

Overview:
- Read-side engine for the HD44780-compatible character LCD in 4-bit mode; the counterpart to the existing write-only display path.
- Performs one 8-bit read as two nibble strobes, high nibble first:
  - RS=0: busy flag plus address counter.
  - RS=1: DDRAM/CGRAM data.
- Optional busy-poll mode repeats BF/AC reads until BF clears or a poll limit is hit.
- Runs in the 4 MHz LCD clock domain; asserts lcd_rd_active so the write path releases the shared nibble bus.

Parameters:
- T_AS, 1, RS/RW setup cycles with EN low before each read sequence (>=1)
- T_EN, 2, EN-high cycles per nibble strobe (>=1)
- T_EL, 2, EN-low cycles after each strobe (>=1)
- MAX_POLLS, 16, maximum BF/AC reads in poll mode before timeout (>=1)

Ports:
- clk  in  1  LCD-domain clock (4 MHz), rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  start a read; accepted when req && ready
- rs_sel  in  1  RS value for the read, captured on accept (0=BF/AC, 1=data)
- poll  in  1  captured on accept; valid only with rs_sel=0; ignored when rs_sel=1
- ready  out  1  high in IDLE only
- rd_valid  out  1  one-cycle pulse; rd_data/busy_flag/timeout valid in this cycle
- rd_data  out  8  assembled byte {high nibble, low nibble}
- busy_flag  out  1  rd_data[7] when rs_sel=0; 0 when rs_sel=1
- timeout  out  1  poll mode ended with BF still 1
- lcd_rd_active  out  1  high from accept until the cycle after the last EN-low
- LCD_RW  out  1  1 while lcd_rd_active, else 0
- LCD_EN  out  1  read strobe
- LCD_RS  out  1  captured rs_sel while active, else 0
- LCD_DATA_IN  in  4  LCD data bus, input side

Behaviour:
- Reset (async, immediate, including mid-sequence):
  - State to IDLE; ready=1.
  - rd_valid, timeout, busy_flag, lcd_rd_active, LCD_RW, LCD_EN, LCD_RS = 0; rd_data = 8'h00.
  - Poll counter cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, HI_EN, HI_LO, LO_EN, LO_LO, DONE.
  - IDLE: on req && ready, capture rs_sel and poll, clear poll counter, go to SETUP. Requests while not ready are ignored and not queued.
  - SETUP: T_AS cycles; RW=1, RS=captured, EN=0.
  - HI_EN: T_EN cycles with EN=1. On the last EN-high cycle edge, rd_data[7:4] <= LCD_DATA_IN.
  - HI_LO: T_EL cycles, EN=0.
  - LO_EN: T_EN cycles with EN=1. On the last EN-high cycle edge, rd_data[3:0] <= LCD_DATA_IN.
  - LO_LO: T_EL cycles, EN=0.
  - Poll decision at the end of LO_LO, when poll=1, rs_sel=0 and rd_data[7]=1:
    - Poll count+1 < MAX_POLLS: increment count, go to SETUP. No rd_valid; RW stays 1 and lcd_rd_active stays high.
    - Otherwise: go to DONE with timeout=1.
  - Any other case at the end of LO_LO: go to DONE with timeout=0.
  - DONE: one cycle. rd_valid=1, busy_flag set per its port rule; timeout per the poll decision. RW, RS and lcd_rd_active drop to 0 in this cycle. Next state is IDLE.
- rd_data, busy_flag and timeout hold their values until the next accepted read. rd_valid is 1 only in DONE.
- Latency: accept at edge k → rd_valid high during cycle k + T_AS + 2*(T_EN+T_EL) + 1.
  - With defaults: 10 cycles, i.e. 2.5 us at 4 MHz.
  - In poll mode, each extra poll adds T_AS + 2*(T_EN+T_EL) cycles.
- req held high continuously: a new read is accepted in the IDLE cycle after DONE, giving at least one idle cycle between reads with RW=0, EN=0.
- Internal counters are sized for max(T_AS, T_EN, T_EL) and MAX_POLLS. They do not wrap in normal operation; the poll counter saturates at MAX_POLLS-1.
- EN never rises in the same cycle RW or RS changes. RW and RS are stable for at least T_AS cycles before every EN rise.

Test Plan:
- Data read (rs_sel=1): LCD_DATA_IN=4'hA during the high strobe and 4'h5 during the low strobe.
  - Expect rd_data=8'hA5, busy_flag=0, timeout=0.
  - Expect rd_valid exactly 10 cycles after accept, and exactly two EN pulses, each 2 cycles wide.
- BF/AC read (rs_sel=0, poll=0): nibbles 4'hC, 4'h3.
  - Expect rd_data=8'hC3, busy_flag=1, timeout=0.
  - Expect LCD_RS=0 and LCD_RW=1 throughout the active period.
- Busy poll: bus returns 8'h80 for 3 reads, then 8'h12.
  - Expect 8 EN pulses and one rd_valid with rd_data=8'h12, busy_flag=0, timeout=0.
  - Expect lcd_rd_active continuously high across all four reads.
- Poll timeout, MAX_POLLS=4: bus returns a constant 8'hFF.
  - Expect exactly 8 EN pulses, then rd_valid with busy_flag=1, timeout=1, rd_data=8'hFF.
- Reset asserted in HI_EN with EN=1: expect EN, RW, RS and lcd_rd_active low immediately, without waiting for a clock edge.
  - After release: ready=1, rd_data=8'h00, no rd_valid.
  - A new request then completes normally.
- Back-to-back: req held high for two reads.
  - Expect RW=0 and EN=0 for at least one IDLE cycle between the reads.
  - Expect the second read's rs_sel captured at its own accept edge.
  - Expect a req pulse arriving mid-read to be ignored.

Source files
------------

// File: rtl/lcd_nibble_reader.sv
// lcd_nibble_reader: HD44780 4-bit read engine (BF/AC or data), with
// optional busy-poll. Two EN strobes per byte, high nibble first.
// Ports: clk/rst (async high); req/rs_sel/poll start a read when ready;
// rd_valid pulses with rd_data/busy_flag/timeout; lcd_rd_active tells the
// write path to release the bus; LCD_RW/LCD_EN/LCD_RS drive the panel and
// LCD_DATA_IN is sampled at the end of each EN-high window.
module lcd_nibble_reader #(
  parameter int T_AS      = 1,
  parameter int T_EN      = 2,
  parameter int T_EL      = 2,
  parameter int MAX_POLLS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  output logic       ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic       timeout,
  output logic       lcd_rd_active,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  input  logic [3:0] LCD_DATA_IN
);

  localparam int TM0  = (T_AS > T_EN) ? T_AS : T_EN;
  localparam int TMAX = (TM0 > T_EL) ? TM0 : T_EL;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW   = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

  localparam logic [CW-1:0] AS_L = CW'(T_AS - 1);
  localparam logic [CW-1:0] EN_L = CW'(T_EN - 1);
  localparam logic [CW-1:0] EL_L = CW'(T_EL - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, HI_EN, HI_LO, LO_EN, LO_LO, DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          rs_q, poll_q;
  logic          last, accept;
  logic          to_dec, active_n, rs_n;

  always_comb begin
    last = 1'b1;
    case (state)
      SETUP:        last = (cnt == AS_L);
      HI_EN, LO_EN: last = (cnt == EN_L);
      HI_LO, LO_LO: last = (cnt == EL_L);
      default:      last = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && req && ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    pcnt_n  = pcnt;
    to_dec  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) begin
          state_n = SETUP;
          pcnt_n  = '0;
        end
      end
      SETUP: if (last) begin
        state_n = HI_EN;
        cnt_n   = '0;
      end
      HI_EN: if (last) begin
        state_n = HI_LO;
        cnt_n   = '0;
      end
      HI_LO: if (last) begin
        state_n = LO_EN;
        cnt_n   = '0;
      end
      LO_EN: if (last) begin
        state_n = LO_LO;
        cnt_n   = '0;
      end
      LO_LO: if (last) begin
        cnt_n   = '0;
        state_n = DONE;
        // Still busy: re-read BF/AC while the poll budget lasts.
        if (poll_q && !rs_q && rd_data[7]) begin
          if (int'(pcnt) + 1 < MAX_POLLS) begin
            pcnt_n  = pcnt + PW'(1);
            state_n = SETUP;
          end else begin
            to_dec = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign active_n = (state_n != IDLE) && (state_n != DONE);
  assign rs_n     = accept ? rs_sel : rs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pcnt          <= '0;
      rs_q          <= 1'b0;
      poll_q        <= 1'b0;
      ready         <= 1'b1;
      rd_valid      <= 1'b0;
      rd_data       <= 8'h00;
      busy_flag     <= 1'b0;
      timeout       <= 1'b0;
      lcd_rd_active <= 1'b0;
      LCD_RW        <= 1'b0;
      LCD_EN        <= 1'b0;
      LCD_RS        <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pcnt  <= pcnt_n;
      if (accept) begin
        rs_q   <= rs_sel;
        poll_q <= poll & ~rs_sel;
      end
      if (state == HI_EN && last) rd_data[7:4] <= LCD_DATA_IN;
      if (state == LO_EN && last) rd_data[3:0] <= LCD_DATA_IN;
      if (state_n == DONE && state != DONE) begin
        timeout   <= to_dec;
        busy_flag <= ~rs_q & rd_data[7];
      end
      // Outputs registered from next state so they align with state.
      ready         <= (state_n == IDLE);
      rd_valid      <= (state_n == DONE);
      lcd_rd_active <= active_n;
      LCD_RW        <= active_n;
      LCD_RS        <= active_n & rs_n;
      LCD_EN        <= (state_n == HI_EN) || (state_n == LO_EN);
    end
  end

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// tb_lcd_nibble_reader: directed vectors plus reset and back-to-back
// sequences against a small LCD bus model.
module tb_lcd_nibble_reader;

  localparam int LAT = 10;
  localparam int PER = 9;

  logic       clk = 1'b0;
  logic       rst, req, rs_sel, poll;
  logic       ready, rd_valid, busy_flag, timeout;
  logic       lcd_rd_active, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] rd_data;
  logic [3:0] data_in = 4'h0;

  int checks = 0;
  int errors = 0;

  logic [7:0] resp [4];
  int         nresp = 1;
  int         nib = 0;
  int         base_nib = 0;

  always #5 clk = ~clk;

  lcd_nibble_reader #(.MAX_POLLS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .rs_sel(rs_sel), .poll(poll),
    .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy_flag(busy_flag), .timeout(timeout),
    .lcd_rd_active(lcd_rd_active), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .LCD_DATA_IN(data_in)
  );

  // Panel model: presents the next nibble when EN rises.
  always @(posedge LCD_EN) begin
    int k;
    int i;
    logic [7:0] b;
    k = nib - base_nib;
    i = k / 2;
    if (i > nresp - 1) i = nresp - 1;
    b = resp[i];
    data_in = k[0] ? b[3:0] : b[7:4];
    nib = nib + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic       poll;
    logic [7:0] r0, r1, r2, r3;
    int         nresp;
    logic [7:0] d;
    logic       bf;
    logic       to;
    int         pulses;
  } vec_t;

  vec_t vecs [7];

  task automatic load(input logic [7:0] a, b, c, d, input int n);
    resp[0] = a; resp[1] = b; resp[2] = c; resp[3] = d;
    nresp = n;
    base_nib = nib;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, run, lat_exp;
    bit got, bad, badw;
    lat_exp = LAT + (v.pulses / 2 - 1) * PER;
    load(v.r0, v.r1, v.r2, v.r3, v.nresp);
    @(negedge clk);
    req = 1'b1; rs_sel = v.rs; poll = v.poll;
    @(posedge clk);
    #1 req = 1'b0; rs_sel = ~v.rs; poll = 1'b0;
    c = 0; run = 0; got = 0; bad = 0; badw = 0;
    while (!got && c < 100) begin
      @(negedge clk);
      c++;
      if (rd_valid) begin
        got = 1;
        chk({tag, " done_idle"},
            {LCD_RW, LCD_EN, LCD_RS, lcd_rd_active}, 0);
        chk({tag, " rd_data"}, rd_data, v.d);
        chk({tag, " busy_flag"}, busy_flag, v.bf);
        chk({tag, " timeout"}, timeout, v.to);
      end else if (!lcd_rd_active || !LCD_RW || LCD_RS !== v.rs || ready) begin
        bad = 1;
      end
      if (LCD_EN) run++;
      else begin
        if (run != 0 && run != 2) badw = 1;
        run = 0;
      end
    end
    chk({tag, " rd_valid_seen"}, got, 1);
    chk({tag, " latency"}, c, lat_exp);
    chk({tag, " en_pulses"}, nib - base_nib, v.pulses);
    chk({tag, " active_bus"}, bad, 0);
    chk({tag, " en_width"}, badw, 0);
    @(negedge clk);
    chk({tag, " back_idle"}, {rd_valid, ready}, 2'b01);
  endtask

  initial begin
    int c, nv;
    bit seen, rsbad;
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b0, 8'hC3, 8'h00, 8'h00, 8'h00, 1, 8'hC3, 1'b1, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h12, 4, 8'h12, 1'b0, 1'b0, 8};
    vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, 8'hFF, 1'b1, 1'b1, 8};
    vecs[4] = '{1'b1, 1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h80, 1'b0, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 8'h7E, 8'h00, 8'h00, 8'h00, 1, 8'h7E, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h80, 1'b1, 1'b0, 2};

    rst = 1'b1; req = 1'b0; rs_sel = 1'b0; poll = 1'b0;
    #2;
    chk("reset_ready", ready, 1);
    chk("reset_outs",
        {rd_valid, busy_flag, timeout, lcd_rd_active, LCD_RW, LCD_EN, LCD_RS}, 0);
    chk("reset_data", rd_data, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while EN is high.
    load(8'hA5, 8'h00, 8'h00, 8'h00, 1);
    @(negedge clk);
    req = 1'b1; rs_sel = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    c = 0;
    while (!LCD_EN && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_en_reached", LCD_EN, 1);
    #1 rst = 1'b1;
    #1 chk("rst_async_drop", {LCD_EN, LCD_RW, LCD_RS, lcd_rd_active}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rel_ready", ready, 1);
    chk("rst_rel_data", rd_data, 8'h00);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_valid || LCD_EN) seen = 1;
    end
    chk("rst_no_valid", seen, 0);
    run_vec(vecs[0], "after_rst");

    // Back-to-back with req held; rs_sel changes after the first accept.
    load(8'hA5, 8'hC3, 8'h00, 8'h00, 2);
    @(negedge clk);
    req = 1'b1; rs_sel = 1'b1; poll = 1'b0;
    @(posedge clk);
    #1 rs_sel = 1'b0;
    nv = 0; c = 0; rsbad = 0;
    while (nv < 2 && c < 60) begin
      @(negedge clk);
      c++;
      if (lcd_rd_active && LCD_RS !== (nv == 0)) rsbad = 1;
      if (rd_valid) begin
        nv++;
        if (nv == 1) begin
          chk("b2b_first_data", rd_data, 8'hA5);
          chk("b2b_first_bf", busy_flag, 0);
          @(negedge clk);
          c++;
          chk("b2b_idle_gap", {LCD_RW, LCD_EN, ready}, 3'b001);
        end else begin
          req = 1'b0;
          chk("b2b_second_data", rd_data, 8'hC3);
          chk("b2b_second_bf", busy_flag, 1);
        end
      end
    end
    req = 1'b0;
    chk("b2b_two_reads", nv, 2);
    chk("b2b_rs_capture", rsbad, 0);

    // A req pulse mid-read is dropped.
    @(negedge clk);
    load(8'h5A, 8'h00, 8'h00, 8'h00, 1);
    @(negedge clk);
    req = 1'b1; rs_sel = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(negedge clk);
    req = 1'b1; rs_sel = 1'b1;
    @(negedge clk);
    req = 1'b0;
    nv = 0; rsbad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_valid) nv++;
      if (LCD_RS) rsbad = 1;
    end
    chk("mid_req_valids", nv, 1);
    chk("mid_req_pulses", nib - base_nib, 2);
    chk("mid_req_data", rd_data, 8'h5A);
    chk("mid_req_rs", rsbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
